// File: rtl/crc8_07_checker.sv
// crc8_07_checker: receive-side CRC-8 (poly 0x07, MSB-first, no reflection,
// no output XOR) frame checker. Each frame is payload bytes followed by the
// transmitted CRC byte, which is flagged with in_last_i. One pass/fail result
// is presented per frame on a valid/ready handshake.
// Optional feature: define CRC8_CHK_STAT_EN for frame/error statistics counters.
module crc8_07_checker #(
  parameter logic [7:0]  INIT_VAL  = 8'h00,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [7:0]           in_data_i,
  input  logic                 in_last_i,
  input  logic                 abort_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 res_ok_o,
  output logic [7:0]           res_crc_o,
  output logic [7:0]           res_rx_o,
  output logic [LEN_WIDTH-1:0] res_len_o
`ifdef CRC8_CHK_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0] frm_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  input  logic                 stat_clr_i
`endif
);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] RESULT = 1'b1;

  logic [0:0]           state_q;
  logic [7:0]           crc_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [7:0]           crc_next;
  logic [LEN_WIDTH-1:0] len_inc;
  logic                 beat;
  logic                 res_hs;

  // One byte through the CRC: XOR in, then 8 MSB-first shifts with poly 0x07.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Handshake qualifiers, next CRC and saturating length increment.
  always_comb begin
    in_ready_o = (state_q == ACCUM);
    beat       = in_valid_i & in_ready_o;
    res_hs     = res_valid_o & res_ready_i;
    crc_next   = crc8_step(crc_q, in_data_i);
    len_inc    = (len_q == '1) ? len_q : len_q + 1'b1;
  end

  // Frame accumulation, result capture and the ACCUM/RESULT sequencing.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ACCUM;
      crc_q       <= INIT_VAL;
      len_q       <= '0;
      res_valid_o <= 1'b0;
      res_ok_o    <= 1'b0;
      res_crc_o   <= '0;
      res_rx_o    <= '0;
      res_len_o   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (abort_i) begin
            // Abort takes priority: any beat taken this cycle is swallowed.
            crc_q <= INIT_VAL;
            len_q <= '0;
          end else if (beat) begin
            if (in_last_i) begin
              res_crc_o   <= crc_q;
              res_rx_o    <= in_data_i;
              res_len_o   <= len_inc;
              res_ok_o    <= (crc_q == in_data_i) && (len_q != '0);
              res_valid_o <= 1'b1;
              state_q     <= RESULT;
            end else begin
              crc_q <= crc_next;
              len_q <= len_inc;
            end
          end
        end
        RESULT: begin
          if (res_hs) begin
            res_valid_o <= 1'b0;
            crc_q       <= INIT_VAL;
            len_q       <= '0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

`ifdef CRC8_CHK_STAT_EN
  // Saturating frame/error counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || stat_clr_i) begin
      frm_cnt_o <= '0;
      err_cnt_o <= '0;
    end else if (res_hs) begin
      if (frm_cnt_o != '1) frm_cnt_o <= frm_cnt_o + 1'b1;
      if (!res_ok_o && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_07_checker.sv
// Scoreboard bench for crc8_07_checker: directed frames push expected results,
// a negedge monitor pops and compares at each result handshake.
// Honours CRC8_CHK_STAT_EN when defined.
module tb_crc8_07_checker;

  localparam int unsigned LW = 16;
  localparam int unsigned CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [7:0]    in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b1;
  logic          res_ok_o;
  logic [7:0]    res_crc_o;
  logic [7:0]    res_rx_o;
  logic [LW-1:0] res_len_o;
`ifdef CRC8_CHK_STAT_EN
  logic [CW-1:0] frm_cnt_o;
  logic [CW-1:0] err_cnt_o;
  logic          stat_clr_i = 1'b0;
`endif

  crc8_07_checker #(.INIT_VAL(8'h00), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_last_i(in_last_i), .abort_i(abort_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_ok_o(res_ok_o),
    .res_crc_o(res_crc_o), .res_rx_o(res_rx_o), .res_len_o(res_len_o)
`ifdef CRC8_CHK_STAT_EN
    , .frm_cnt_o(frm_cnt_o), .err_cnt_o(err_cnt_o), .stat_clr_i(stat_clr_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          ok;
    logic [7:0]    crc;
    logic [7:0]    rx;
    logic [LW-1:0] len;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Count accepted input beats for the no-early-accept check.
  always @(posedge clk_i) if (rst_n_i && in_valid_i && in_ready_o) accepts++;

`ifdef CRC8_CHK_STAT_EN
  int unsigned m_frm = 0;
  int unsigned m_err = 0;
  logic        m_live = 1'b0;
`endif

  // Monitor: compares each result at its handshake against the scoreboard head.
  always @(negedge clk_i) begin
    exp_t e;
    logic hs;
    hs = rst_n_i && res_valid_o && res_ready_i;
    e  = '0;
    if (hs) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(res_valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res_ok",  32'(res_ok_o),  32'(e.ok));
        chk("res_crc", 32'(res_crc_o), 32'(e.crc));
        chk("res_rx",  32'(res_rx_o),  32'(e.rx));
        chk("res_len", 32'(res_len_o), 32'(e.len));
      end
    end
`ifdef CRC8_CHK_STAT_EN
    if (m_live && rst_n_i) begin
      chk("frm_cnt", 32'(frm_cnt_o), m_frm);
      chk("err_cnt", 32'(err_cnt_o), m_err);
    end
    if (!rst_n_i) begin
      m_frm = 0; m_err = 0; m_live = 1'b1;
    end else if (stat_clr_i) begin
      m_frm = 0; m_err = 0;
    end else if (hs) begin
      m_frm++;
      if (!e.ok) m_err++;
    end
`endif
  end

  task automatic push(input logic ok, input logic [7:0] crc, input logic [7:0] rx, input int unsigned len);
    exp_t e;
    e.ok = ok; e.crc = crc; e.rx = rx; e.len = LW'(len);
    sb.push_back(e);
  endtask

  // Drive one beat and wait (bounded) for it to be accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int unsigned n;
    logic acc;
    n = 0;
    in_valid_i = 1'b1; in_data_i = d; in_last_i = l;
    do begin
      acc = in_ready_o;
      @(posedge clk_i);
      n++;
    end while (!acc && n < 200);
    #1;
    in_valid_i = 1'b0; in_last_i = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    if (l) chk("res_valid_latency", 32'(res_valid_o), 32'd1);
  endtask

  task automatic send_check_frame(input logic [7:0] crc_byte);
    for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), 1'b0);
    send(crc_byte, 1'b1);
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || res_valid_o) && n < 200) begin
      @(posedge clk_i); n++;
    end
    #1;
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned acc0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_res_ok",    32'(res_ok_o),    32'd0);
    chk("rst_res_crc",   32'(res_crc_o),   32'd0);
    chk("rst_res_len",   32'(res_len_o),   32'd0);
    rst_n_i = 1'b1;
    #1;
    chk("rst_in_ready",  32'(in_ready_o),  32'd1);

    // "123456789" + correct CRC 0xF4
    push(1'b1, 8'hF4, 8'hF4, 10);
    send_check_frame(8'hF4);
    wait_drain();

`ifdef CRC8_CHK_STAT_EN
    stat_clr_i = 1'b1; @(posedge clk_i); #1; stat_clr_i = 1'b0;
`endif
    // Same payload, wrong CRC byte
    push(1'b0, 8'hF4, 8'hF5, 10);
    send_check_frame(8'hF5);
    wait_drain();
`ifdef CRC8_CHK_STAT_EN
    chk("stat_frm_after_bad", 32'(frm_cnt_o), 32'd1);
    chk("stat_err_after_bad", 32'(err_cnt_o), 32'd1);
`endif

    // Single-byte frame: zero CRC matches but length too short
    push(1'b0, 8'h00, 8'h00, 1);
    send(8'h00, 1'b1);
    wait_drain();

    // {0x01, 0x07} held for 5 cycles with a pending next byte
    res_ready_i = 1'b0;
    push(1'b1, 8'h07, 8'h07, 2);
    send(8'h01, 1'b0);
    send(8'h07, 1'b1);
    push(1'b0, 8'h00, 8'h00, 1);
    in_valid_i = 1'b1; in_data_i = 8'h00; in_last_i = 1'b1;
    acc0 = accepts;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hold_valid",    32'(res_valid_o), 32'd1);
      chk("hold_in_ready", 32'(in_ready_o),  32'd0);
      chk("hold_ok",       32'(res_ok_o),    32'd1);
      chk("hold_crc",      32'(res_crc_o),   32'h07);
      chk("hold_len",      32'(res_len_o),   32'd2);
      @(posedge clk_i);
    end
    #1;
    res_ready_i = 1'b1;
    @(negedge clk_i);
    chk("hs_cycle_in_ready", 32'(in_ready_o), 32'd0);
    @(posedge clk_i); #1;
    chk("no_early_accept", accepts - acc0, 32'd0);
    chk("post_hs_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; in_last_i = 1'b0;
    chk("pending_accepted", accepts - acc0, 32'd1);
    chk("pending_res_valid", 32'(res_valid_o), 32'd1);
    wait_drain();

    // Abort with a simultaneous (last) beat, then a clean frame
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
    in_valid_i = 1'b1; in_data_i = 8'h55; in_last_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; in_last_i = 1'b0; abort_i = 1'b0;
    chk("abort_no_result", 32'(res_valid_o), 32'd0);
    push(1'b1, 8'h07, 8'h07, 2);
    send(8'h01, 1'b0);
    send(8'h07, 1'b1);
    wait_drain();

`ifdef CRC8_CHK_STAT_EN
    // Clear coinciding with a failing result handshake
    res_ready_i = 1'b0;
    push(1'b0, 8'h00, 8'h00, 1);
    send(8'h00, 1'b1);
    res_ready_i = 1'b1; stat_clr_i = 1'b1;
    @(posedge clk_i); #1;
    stat_clr_i = 1'b0;
    chk("clr_wins_frm", 32'(frm_cnt_o), 32'd0);
    chk("clr_wins_err", 32'(err_cnt_o), 32'd0);
    wait_drain();
`endif

    repeat (3) @(posedge clk_i);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc8_07_checker.md
Name: crc8_07_checker

Overview:
- Receive-side streaming checker for CRC-8, polynomial x^8+x^2+x+1 (0x07), left-shifting (MSB-first), no reflection, no output XOR.
- Accepts a byte stream over a valid/ready handshake. Each frame is payload bytes followed by one transmitted CRC byte, delimited by a last flag.
- Issues one pass/fail result per frame on a second valid/ready handshake.
- Sits at the end of a link, opposite the CRC-8 generator used on the transmit side.

Parameters:
- INIT_VAL, 8'h00, CRC register value at frame start; must match the transmitter.
- LEN_WIDTH, 16, width of the frame byte counter.
- CNT_WIDTH, 16, width of the statistics counters (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- in_valid_i  in  1  input byte valid
- in_ready_o  out  1  checker can accept a byte
- in_data_i  in  8  input byte
- in_last_i  in  1  this byte is the transmitted CRC and closes the frame
- abort_i  in  1  discard the frame in progress
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed
- res_ok_o  out  1  CRC matched and frame length >= 2
- res_crc_o  out  8  CRC computed over the payload (excludes the last byte)
- res_rx_o  out  8  received CRC byte (the last byte)
- res_len_o  out  LEN_WIDTH  bytes accepted in the frame, including the CRC byte
- frm_cnt_o  out  CNT_WIDTH  frames completed (CRC8_CHK_STAT_EN only)
- err_cnt_o  out  CNT_WIDTH  frames with res_ok_o=0 (CRC8_CHK_STAT_EN only)
- stat_clr_i  in  1  clear statistics counters (CRC8_CHK_STAT_EN only)

Behaviour:
- Step function: next = T(crc ^ byte), where T is 8 MSB-first shifts with conditional XOR of 0x07. Purely combinational, instantiated inside this block.
- Reset: everything below is synchronous on rst_n_i=0, effective the same cycle edge as any other update.
  - State ACCUM, crc_q=INIT_VAL, len_q=0.
  - res_valid_o=0, res_ok_o=0, res_crc_o=0, res_rx_o=0, res_len_o=0.
  - frm_cnt_o=0, err_cnt_o=0.
  - Reset mid-frame or mid-result drops everything with no result emitted.
- State ACCUM:
  - in_ready_o=1; a beat is accepted when in_valid_i & in_ready_o.
  - Non-last beat: crc_q <= next, len_q <= len_q+1, saturating at all-ones.
  - Last beat:
    - res_crc_o <= crc_q (pre-update value), res_rx_o <= in_data_i, res_len_o <= len_q+1 (saturating).
    - res_ok_o <= (crc_q == in_data_i) && (len_q >= 1).
    - res_valid_o <= 1; go to RESULT. The result is visible the cycle after the last beat.
  - abort_i=1: crc_q <= INIT_VAL, len_q <= 0. A beat accepted the same cycle is consumed and dropped, last included; abort wins and no result is emitted.
- State RESULT:
  - in_ready_o=0; abort_i is ignored.
  - Result outputs are held stable while res_valid_o=1 and res_ready_i=0.
  - On res_valid_o & res_ready_i: res_valid_o <= 0, crc_q <= INIT_VAL, len_q <= 0, go to ACCUM.
  - The next byte can be accepted the cycle after the handshake. There is no combinational ready-to-ready path.
- Boundary cases:
  - Single-byte frame (last on the first beat): res_ok_o=0, res_len_o=1, res_crc_o=INIT_VAL.
  - Length counter saturation does not affect the CRC result.
  - in_last_i and in_data_i are don't-care when in_valid_i=0.
- The match condition is equivalent to a zero residue after running the CRC byte through T.

Optional Feature:
- Macro: CRC8_CHK_STAT_EN.
- Defined:
  - frm_cnt_o, err_cnt_o and stat_clr_i exist.
  - On each result handshake, frm_cnt_o increments, and err_cnt_o increments if res_ok_o=0. Both saturate at all-ones.
  - stat_clr_i=1 zeroes both the next cycle. Clear wins over a simultaneous increment.
- Not defined:
  - The three ports and both counters are absent; all other behaviour is identical.

Test Plan:
- ASCII "123456789" (0x31..0x39) then 0xF4 with last, INIT_VAL=0, res_ready_i=1 -> res_valid_o one cycle after the last beat, res_ok_o=1, res_crc_o=0xF4, res_rx_o=0xF4, res_len_o=10.
- Same frame but CRC byte 0xF5 -> res_ok_o=0, res_crc_o=0xF4, res_rx_o=0xF5; with the macro defined, frm_cnt_o=1 and err_cnt_o=1.
- Single beat 0x00 with last -> res_ok_o=0, res_len_o=1, res_crc_o=0x00.
- Frame {0x01, 0x07 last} with res_ready_i held low 5 cycles:
  - Result is res_ok_o=1, res_crc_o=0x07, with outputs stable and in_ready_o=0 for 5 cycles.
  - A pending next-frame byte is not accepted until the cycle after the handshake.
- Bytes 0xAA, 0xBB, 0xCC, then abort_i with a simultaneous valid byte, then {0x01, 0x07 last} -> single result only: res_ok_o=1, res_len_o=2.
- With the macro defined: stat_clr_i asserted in the same cycle as a failing result handshake -> frm_cnt_o=0 and err_cnt_o=0 the next cycle.
